// File: rtl/encoder_pkg.sv
// encoder_pkg: shared types and constants for encoder16x4_serial.
//
// Contents:
//   state_e    - scan controller states (IDLE, SCAN)
//   idx_width  - width of an index into an n-bit word
//   MSB_FIRST  - scan order; set by defining ENC_MSB_FIRST_EN
//
// Build option:
//   ENC_MSB_FIRST_EN  defined   -> highest set index emitted first
//                     undefined -> lowest set index emitted first (default)
package encoder_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   // A 2-bit word still needs a 1-bit index, so clamp to at least 1.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

`ifdef ENC_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

endpackage

// File: rtl/bit_index_find.sv
// bit_index_find: combinational priority finder.
//
// Returns the index of the lowest set bit of vec (or the highest when the
// ENC_MSB_FIRST_EN build option is defined), plus a flag that any bit is set.
// index is 0 when no bit is set.
//
// Ports:
//   vec     [N-1:0]      input vector
//   index   [IDX_W-1:0]  selected bit position
//   any_set              at least one bit of vec is set
module bit_index_find
   import encoder_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] index,
   output logic             any_set
);

   always_comb begin
      index   = '0;
      any_set = |vec;
      // The scan direction is chosen so the last hit in loop order is the
      // wanted bit: walk upward for MSB-first, downward for LSB-first.
      if (MSB_FIRST) begin
         for (int b = 0; b < int'(N); b++) begin
            if (vec[b]) index = IDX_W'(b);
         end
      end else begin
         for (int b = int'(N) - 1; b >= 0; b--) begin
            if (vec[b]) index = IDX_W'(b);
         end
      end
   end

endmodule

// File: rtl/encoder16x4_serial.sv
// encoder16x4_serial: serial bit-vector to index encoder.
//
// A request word is captured on an accepted load (en while not busy). Each
// set bit is then presented as a binary index on q, one per valid/ready
// handshake. done pulses for one cycle after the last index is consumed, or
// one cycle after a load of an all-zero word.
//
// Build option: ENC_MSB_FIRST_EN selects highest-index-first order.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   i      [N-1:0] request word, sampled only on an accepted load
//   en     load strobe, ignored while busy
//   ready  consumer takes q this cycle
//   q      [IDX_W-1:0] index of current set bit, 0 when valid is low
//   valid  q holds a legal index
//   busy   a word is being scanned
//   done   one-cycle completion pulse
module encoder16x4_serial
   import encoder_pkg::*;
#(
   parameter int unsigned N = 16,
   localparam int unsigned IDX_W = idx_width(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i,
   input  logic             en,
   input  logic             ready,
   output logic [IDX_W-1:0] q,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   state_e           state_q;
   logic [N-1:0]     pending_q;
   logic [N-1:0]     pending_clr;
   logic [IDX_W-1:0] idx;
   logic             any_set;
   logic             last_bit;

   bit_index_find #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_find (
      .vec     (pending_q),
      .index   (idx),
      .any_set (any_set)
   );

   // pending with the currently presented bit removed, i.e. the word that
   // remains after a handshake.
   always_comb begin
      pending_clr      = pending_q;
      pending_clr[idx] = 1'b0;
      last_bit         = (pending_clr == '0);
      q                = (valid && any_set) ? idx : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (en) begin
                  if (i != '0) begin
                     pending_q <= i;
                     state_q   <= SCAN;
                     valid     <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            SCAN: begin
               // en is deliberately not looked at here, even on the final
               // handshake; the next word is taken in the following IDLE cycle.
               if (ready) begin
                  pending_q <= pending_clr;
                  if (last_bit) begin
                     state_q <= IDLE;
                     valid   <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               pending_q <= '0;
               valid     <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_encoder16x4_serial.sv
// tb_encoder16x4_serial: self-checking bench for encoder16x4_serial.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven
// at the same point so they are stable well before the next edge.
module tb_encoder16x4_serial;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] i   = '0;
   logic        en  = 1'b0;
   logic        ready = 1'b0;
   logic [3:0]  q;
   logic        valid;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;

   encoder16x4_serial #(
      .N (N)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .i     (i),
      .en    (en),
      .ready (ready),
      .q     (q),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the ordered list of indices a word should produce.
   function automatic void model_indices(input logic [15:0] w, output int list[$]);
      list = {};
      for (int b = 0; b < N; b++) begin
         if (w[b]) begin
`ifdef ENC_MSB_FIRST_EN
            list.push_front(b);
`else
            list.push_back(b);
`endif
         end
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; i = 16'hFFFF; ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         tests++;
         if ({q, valid, busy, done} !== 7'b0) begin
            fails++;
            $display("FAIL reset_cycle%0d: q=%0d valid=%b busy=%b done=%b, need all 0",
                     c, q, valid, busy, done);
         end
      end
      rst = 1'b0; en = 1'b0;
      tick();
      tests++;
      if ({valid, busy, done} !== 3'b0) begin
         fails++;
         $display("FAIL reset_noload: valid=%b busy=%b done=%b, need 0 0 0", valid, busy, done);
      end
   endtask

   task automatic test_basic();
      int exp[$];
      model_indices(16'h0006, exp);
      i = 16'h0006; en = 1'b1; ready = 1'b1;
      tick();
      en = 1'b0; i = 16'hA5A5;
      for (int k = 0; k < 2; k++) begin
         tests++;
         if ({valid, busy, done, q} !== {3'b110, 4'(exp[k])}) begin
            fails++;
            $display("FAIL basic_idx%0d: valid=%b busy=%b done=%b q=%0d, need 1 1 0 q=%0d",
                     k, valid, busy, done, q, exp[k]);
         end
         tick();
      end
      tests++;
      if ({valid, busy, done, q} !== 7'b0010000) begin
         fails++;
         $display("FAIL basic_done: valid=%b busy=%b done=%b q=%0d, need 0 0 1 q=0",
                  valid, busy, done, q);
      end
      tick();
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL basic_done_pulse: done=%b, need 0", done);
      end
   endtask

   task automatic test_backpressure();
      int exp[$];
      model_indices(16'h8001, exp);
      i = 16'h8001; en = 1'b1; ready = 1'b0;
      tick();
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tests++;
         if ({valid, busy, done, q} !== {3'b110, 4'(exp[0])}) begin
            fails++;
            $display("FAIL bp_hold%0d: valid=%b busy=%b done=%b q=%0d, need 1 1 0 q=%0d",
                     c, valid, busy, done, q, exp[0]);
         end
         if (c < 2) tick();
      end
      ready = 1'b1;
      tick();
      tests++;
      if ({valid, q} !== {1'b1, 4'(exp[1])}) begin
         fails++;
         $display("FAIL bp_second: valid=%b q=%0d, need 1 q=%0d", valid, q, exp[1]);
      end
      tick();
      tests++;
      if ({valid, busy, done} !== 3'b001) begin
         fails++;
         $display("FAIL bp_done: valid=%b busy=%b done=%b, need 0 0 1", valid, busy, done);
      end
      tick();
   endtask

   task automatic test_zero_word();
      i = 16'h0000; en = 1'b1; ready = 1'b1;
      tick();
      en = 1'b0;
      tests++;
      if ({valid, busy, done} !== 3'b001) begin
         fails++;
         $display("FAIL zero_done: valid=%b busy=%b done=%b, need 0 0 1", valid, busy, done);
      end
      tick();
      tests++;
      if ({valid, busy, done} !== 3'b000) begin
         fails++;
         $display("FAIL zero_after: valid=%b busy=%b done=%b, need 0 0 0", valid, busy, done);
      end
   endtask

   task automatic test_back_to_back();
      i = 16'h0010; en = 1'b1; ready = 1'b1;
      tick();
      // Final handshake cycle: the new word must be ignored here.
      i = 16'h0100;
      tests++;
      if ({valid, busy, q} !== {2'b11, 4'd4}) begin
         fails++;
         $display("FAIL b2b_first: valid=%b busy=%b q=%0d, need 1 1 q=4", valid, busy, q);
      end
      tick();
      tests++;
      if ({valid, busy, done} !== 3'b001) begin
         fails++;
         $display("FAIL b2b_done: valid=%b busy=%b done=%b, need 0 0 1", valid, busy, done);
      end
      tick();
      en = 1'b0;
      tests++;
      if ({valid, busy, done, q} !== {3'b110, 4'd8}) begin
         fails++;
         $display("FAIL b2b_second: valid=%b busy=%b done=%b q=%0d, need 1 1 0 q=8",
                  valid, busy, done, q);
      end
      tick();
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL b2b_second_done: done=%b, need 1", done);
      end
      tick();
   endtask

   task automatic test_midscan_reset();
      int exp[$];
      model_indices(16'hFFFF, exp);
      i = 16'hFFFF; en = 1'b1; ready = 1'b1;
      tick();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tests++;
         if ({valid, q} !== {1'b1, 4'(exp[k])}) begin
            fails++;
            $display("FAIL midrst_idx%0d: valid=%b q=%0d, need 1 q=%0d", k, valid, q, exp[k]);
         end
         if (k < 4) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({q, valid, busy, done} !== 7'b0) begin
         fails++;
         $display("FAIL midrst_clear: q=%0d valid=%b busy=%b done=%b, need all 0",
                  q, valid, busy, done);
      end
      tick();
      tests++;
      if ({valid, busy, done} !== 3'b000) begin
         fails++;
         $display("FAIL midrst_nodone: valid=%b busy=%b done=%b, need 0 0 0", valid, busy, done);
      end
   endtask

   task automatic test_random();
      int          exp[$];
      logic [15:0] w;
      int          budget;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0:       w = 16'h0000;
            1:       w = 16'hFFFF;
            2:       w = 16'(1 << $urandom_range(0, 15));
            default: w = 16'($urandom) & 16'($urandom);
         endcase
         model_indices(w, exp);
         i = w; en = 1'b1; ready = 1'($urandom);
         tick();
         budget = 0;
         while (exp.size() != 0) begin
            tests++;
            if ({valid, busy, done, q} !== {3'b110, 4'(exp[0])}) begin
               fails++;
               $display("FAIL rand_w%0d_%h: valid=%b busy=%b done=%b q=%0d, need 1 1 0 q=%0d",
                        n, w, valid, busy, done, q, exp[0]);
            end
            // Scramble i and poke en while busy; neither may disturb the scan.
            i     = 16'($urandom);
            ready = (budget > 60) ? 1'b1 : 1'($urandom);
            en    = (ready && exp.size() == 1) ? 1'b0 : 1'($urandom);
            if (ready) void'(exp.pop_front());
            budget++;
            tick();
         end
         en = 1'b0;
         tests++;
         if ({valid, busy, done} !== 3'b001) begin
            fails++;
            $display("FAIL rand_done_w%0d_%h: valid=%b busy=%b done=%b, need 0 0 1",
                     n, w, valid, busy, done);
         end
         if ($urandom_range(0, 1) == 0) begin
            tick();
            tests++;
            if ({valid, busy, done} !== 3'b000) begin
               fails++;
               $display("FAIL rand_idle_w%0d: valid=%b busy=%b done=%b, need 0 0 0",
                        n, valid, busy, done);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_word();
      test_back_to_back();
      test_midscan_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/encoder16x4_serial.md
Name: encoder16x4_serial

Overview:
- Inverse companion of the 4x16 decoder: accepts a 16-bit request word and serially emits the 4-bit index of every set bit, one per handshake.
- Scans lowest index first by default.
- Sits downstream of decoder/request logic and converts bit vectors back to binary indices for consumers with valid/ready flow control.

Parameters:
- N, 16, width of input word; power of two, 2..64.
- IDX_W, $clog2(N) = 4, width of emitted index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- i  input  N  request word; sampled only on accepted load
- en  input  1  load strobe; accepted only when busy=0
- ready  input  1  consumer accepts q this cycle
- q  output  IDX_W  index of current set bit; 0 when valid=0
- valid  output  1  q holds a legal index
- busy  output  1  word being scanned; en ignored
- done  output  1  one-cycle pulse after last index consumed, or after a load of an all-zero word

Behaviour:
- Reset state (rst=1 at clk edge): state=IDLE, pending=0, q=0, valid=0, busy=0, done=0. Reset has priority over all inputs.
- Reset mid-scan: the remaining bits are discarded, and no done pulse is produced.
- States:
  - IDLE, busy=0, valid=0.
    - en=1 and i!=0 -> pending<=i, go to SCAN.
    - en=1 and i==0 -> done=1 next cycle, stay in IDLE.
  - SCAN, busy=1, valid=1, q=lowest set index of pending (combinational from the pending register).
    - valid&&ready -> clear bit q in pending.
    - If that was the only set bit -> go to IDLE and assert done=1 on the next cycle.
- done is registered. It is high for exactly one cycle and is otherwise 0.
- Latency: en accepted at edge t -> valid=1 in the cycle after t. With ready held high, one index per cycle. A word with k set bits gives done k+1 cycles after the load edge.
- Backpressure: with ready=0, q and valid hold steady and pending is unchanged.
- en while busy=1 is ignored, including in the cycle of the final handshake. A new word is accepted in the first IDLE cycle, which may coincide with done=1.
- Changes to i after load have no effect. Only the captured copy is scanned.
- All-ones word: emits 0..N-1 in order, then done.
- Single-bit word, e.g. i=1<<15: q=15 for one handshake, then done.

Optional Feature:
- Macro: ENC_MSB_FIRST_EN.
- Defined: q is the highest set index of pending, so indices are emitted in descending order.
- Undefined: lowest set index first (default).
- Handshake, latency and done behaviour are identical in both builds.

Decomposition:
- Package encoder_pkg:
  - state enum {IDLE, SCAN};
  - IDX_W computation function;
  - scan-order constant driven by ENC_MSB_FIRST_EN.
- Sub-module bit_index_find:
  - combinational; parameters N and IDX_W;
  - input vector, outputs index and any_set;
  - direction selected by the macro.
  - Instantiated once on pending.

Test Plan:
- Reset behaviour:
  - Stimulus: rst=1 for 2 cycles with en=1, i=16'hFFFF.
  - Response: q=0, valid=0, busy=0, done=0 throughout; no load after rst drops unless en is still high.
- Basic scan:
  - Stimulus: i=16'h0006 (bit pattern 0110), en=1 for one cycle, ready=1.
  - Response: q=1 valid, then q=2 valid, then done=1, busy=0. With ENC_MSB_FIRST_EN: q=2 then q=1.
- Backpressure:
  - Stimulus: i=16'h8001, ready=0 for 3 cycles then 1.
  - Response: q=0 and valid=1 stable for 3 cycles, then q=15, then done.
- Zero word:
  - Stimulus: i=0, en=1.
  - Response: valid never rises; done=1 exactly one cycle later; busy stays 0.
- Load during scan and back-to-back loads:
  - Stimulus: i=16'h0010 loaded; en=1, i=16'h0100 held through the final handshake.
  - Response: second word ignored during that cycle; accepted the next cycle (done=1 same cycle); q=8 follows.
- Mid-scan reset:
  - Stimulus: i=16'hFFFF loaded, reset after 5 handshakes (q=0..4 emitted).
  - Response: all outputs 0 next cycle; no done pulse.
